// File: rtl/alu_exec_if.sv
// alu_exec_if: issue, ALU-drive and writeback bundle of the execute stage.
// slave = execute stage side, master = upstream/ALU/writeback side.
interface alu_exec_if #(
  parameter int RD_W = 5,
  parameter int W    = 48
);
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_a;
  logic [W-1:0]    in_b;
  logic [5:0]      in_op;
  logic [5:0]      in_shamt;
  logic            in_swap;
  logic [RD_W-1:0] in_rd;
  logic            in_wb_en;
  logic            in_br_en;
  logic [2:0]      in_br_cond;
  logic [W-1:0]    in_br_target;

  logic [W-1:0]    alu_a;
  logic [W-1:0]    alu_b;
  logic [5:0]      alu_op;
  logic [5:0]      alu_shamt;
  logic [W-1:0]    alu_y;
  logic            alu_eq;
  logic            alu_lt_s;
  logic            alu_lt_u;

  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_y;
  logic [RD_W-1:0] out_rd;
  logic            out_wb_en;
  logic            out_br_taken;
  logic [W-1:0]    out_br_target;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_shamt,
    input  in_swap, in_rd, in_wb_en, in_br_en,
    input  in_br_cond, in_br_target,
    output in_ready,
    output alu_a, alu_b, alu_op, alu_shamt,
    input  alu_y, alu_eq, alu_lt_s, alu_lt_u,
    output out_valid, out_y, out_rd, out_wb_en,
    output out_br_taken, out_br_target, out_illegal,
    input  out_ready
  );

  modport master (
    output in_valid, in_a, in_b, in_op, in_shamt,
    output in_swap, in_rd, in_wb_en, in_br_en,
    output in_br_cond, in_br_target,
    input  in_ready,
    input  alu_a, alu_b, alu_op, alu_shamt,
    output alu_y, alu_eq, alu_lt_s, alu_lt_u,
    input  out_valid, out_y, out_rd, out_wb_en,
    input  out_br_taken, out_br_target, out_illegal,
    output out_ready
  );
endinterface

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: drives alu48, captures result/branch outcome, 2-deep FIFO.
// Ports: clk, rst (async high), flush (sync kill), bus (alu_exec_if.slave).
module alu_exec_stage #(
  parameter int RD_W = 5,
  parameter int W    = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  alu_exec_if.slave  bus
);

  typedef struct packed {
    logic [W-1:0]    y;
    logic [RD_W-1:0] rd;
    logic            wb_en;
    logic            br_taken;
    logic [W-1:0]    br_target;
    logic            illegal;
  } ent_t;

  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_AND = 6'h02;
  localparam logic [5:0] OP_OR  = 6'h03;
  localparam logic [5:0] OP_XOR = 6'h04;
  localparam logic [5:0] OP_SLL = 6'h05;
  localparam logic [5:0] OP_SRL = 6'h06;
  localparam logic [5:0] OP_MAX = 6'h08;
  localparam logic [5:0] SH_MAX = 6'd47;

  logic       w_comm;
  logic       w_swap;
  logic       w_legal;
  logic       w_wide;
  logic       w_taken;
  logic       w_push;
  logic       w_pop;
  logic [1:0] w_cnt_nxt;
  ent_t       w_ent;

  ent_t       r_mem [2];
  logic       r_wr;
  logic       r_rd;
  logic [1:0] r_count;
  logic       r_in_ready;

  // Swapping only matters for operand routing; branches need a/b order.
  assign w_comm = (bus.in_op == OP_ADD) | (bus.in_op == OP_AND)
                | (bus.in_op == OP_OR)  | (bus.in_op == OP_XOR);
  assign w_swap = bus.in_swap & w_comm & ~bus.in_br_en;

  assign bus.alu_a     = w_swap ? bus.in_b : bus.in_a;
  assign bus.alu_b     = w_swap ? bus.in_a : bus.in_b;
  assign bus.alu_op    = bus.in_op;
  assign bus.alu_shamt = (bus.in_shamt > SH_MAX) ? SH_MAX
                                                 : bus.in_shamt;

  assign w_legal = (bus.in_op <= OP_MAX);
  assign w_wide  = (bus.in_shamt >= 6'd48);

  always_comb begin
    w_taken = 1'b0;
    if (bus.in_br_en) begin
      unique case (bus.in_br_cond)
        3'd0: w_taken = bus.alu_eq;
        3'd1: w_taken = ~bus.alu_eq;
        3'd2: w_taken = bus.alu_lt_s;
        3'd3: w_taken = ~bus.alu_lt_s;
        3'd4: w_taken = bus.alu_lt_u;
        3'd5: w_taken = ~bus.alu_lt_u;
        3'd6: w_taken = 1'b1;
        3'd7: w_taken = 1'b0;
      endcase
    end
  end

  // Logical shifts past the width clear; SRA relies on the shamt clamp.
  always_comb begin
    w_ent.y         = bus.alu_y;
    w_ent.rd        = bus.in_rd;
    w_ent.wb_en     = bus.in_wb_en & w_legal;
    w_ent.br_taken  = w_taken;
    w_ent.br_target = bus.in_br_target;
    w_ent.illegal   = ~w_legal;
    if (!w_legal) begin
      w_ent.y = '0;
    end else if (w_wide && (bus.in_op == OP_SLL ||
                            bus.in_op == OP_SRL)) begin
      w_ent.y = '0;
    end
  end

  assign w_push = bus.in_valid & r_in_ready;
  assign w_pop  = bus.out_valid & bus.out_ready;

  always_comb begin
    w_cnt_nxt = r_count;
    if (flush) begin
      w_cnt_nxt = 2'd0;
    end else if (w_push && !w_pop) begin
      w_cnt_nxt = r_count + 2'd1;
    end else if (!w_push && w_pop) begin
      w_cnt_nxt = r_count - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_wr       <= 1'b0;
      r_rd       <= 1'b0;
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
    end else begin
      r_count    <= w_cnt_nxt;
      r_in_ready <= (w_cnt_nxt != 2'd2);
      if (flush) begin
        r_wr <= 1'b0;
        r_rd <= 1'b0;
      end else begin
        if (w_push) begin
          r_mem[r_wr] <= w_ent;
          r_wr        <= ~r_wr;
        end
        if (w_pop) begin
          r_rd <= ~r_rd;
        end
      end
    end
  end

  assign bus.in_ready      = r_in_ready;
  assign bus.out_valid     = (r_count != 2'd0);
  assign bus.out_y         = r_mem[r_rd].y;
  assign bus.out_rd        = r_mem[r_rd].rd;
  assign bus.out_wb_en     = r_mem[r_rd].wb_en;
  assign bus.out_br_taken  = r_mem[r_rd].br_taken;
  assign bus.out_br_target = r_mem[r_rd].br_target;
  assign bus.out_illegal   = r_mem[r_rd].illegal;

endmodule
